// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall handshake between the pipeline datapath and its controller.
// master = datapath side (reports hits/hazards), slave = controller side.
interface pipeline_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             ihit;
   logic             dhit;
   logic             dREN_mem;
   logic             dWEN_mem;
   logic             halt_mem;
   logic             redirect_mem;
   logic             idex_dREN;
   logic [4:0]       idex_rt;
   logic [4:0]       ifid_rs;
   logic [4:0]       ifid_rt;
   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output ihit, dhit, dREN_mem, dWEN_mem, halt_mem, redirect_mem,
             idex_dREN, idex_rt, ifid_rs, ifid_rt,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, halted, stall_cnt
   );

   modport slave (
      input  ihit, dhit, dREN_mem, dWEN_mem, halt_mem, redirect_mem,
             idex_dREN, idex_rt, ifid_rs, ifid_rt,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, halted, stall_cnt
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline stall/flush controller: memory waits, load-use hazards,
// branch redirects, halt, and a saturating PC-stall counter.
module pipeline_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic          CLK,
   input  logic          RST,
   pipeline_ctrl_if.slave pif
);
   typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

   state_t           state_reg, state_next;
   logic             if_pend_reg, if_pend_next;
   logic [CNT_W-1:0] stall_cnt_reg;

   logic load_use, dmiss, run_eval;
   logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;

   assign load_use = pif.idex_dREN && (pif.idex_rt != 5'd0) &&
                     ((pif.idex_rt == pif.ifid_rs) || (pif.idex_rt == pif.ifid_rt));
   assign dmiss    = (pif.dREN_mem || pif.dWEN_mem) && !pif.dhit;

   always_comb begin
      state_next = state_reg;
      run_eval   = 1'b0;
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;

      case (state_reg)
         RUN: begin
            if (pif.halt_mem)  state_next = HALT;
            else if (dmiss)    state_next = DWAIT;
            else               run_eval   = 1'b1;
         end
         DWAIT: begin
            // halt_mem is not looked at here: the frozen EX/MEM latch re-presents it after the wait
            if (pif.dhit) begin
               state_next = RUN;
               run_eval   = 1'b1;
            end
         end
         HALT:    state_next = HALT;
         default: state_next = RUN;
      endcase

      if (run_eval) begin
         exmem_en = 1'b1;
         memwb_en = 1'b1;
         idex_en  = 1'b1;
         if (pif.redirect_mem) begin
            // redirect squashes the ID instruction, so any load-use on it is moot
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (load_use) begin
            idex_flush = 1'b1;
         end else if (!(pif.ihit || if_pend_reg)) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
         end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
         end
      end
   end

   always_comb begin
      if_pend_next = if_pend_reg;
      if (state_reg != HALT) begin
         if (pc_en)         if_pend_next = 1'b0;
         else if (pif.ihit) if_pend_next = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg     <= RUN;
         if_pend_reg   <= 1'b0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         if_pend_reg <= if_pend_next;
         if ((state_reg != HALT) && !pc_en && (stall_cnt_reg != {CNT_W{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
   end

   assign pif.pc_en      = pc_en;
   assign pif.ifid_en    = ifid_en;
   assign pif.idex_en    = idex_en;
   assign pif.exmem_en   = exmem_en;
   assign pif.memwb_en   = memwb_en;
   assign pif.ifid_flush = ifid_flush;
   assign pif.idex_flush = idex_flush;
   assign pif.halted     = (state_reg == HALT);
   assign pif.stall_cnt  = stall_cnt_reg;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic against a rule-level reference model.
module tb_pipeline_ctrl;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted}
   localparam logic [7:0] O_RUN    = 8'b11111000;
   localparam logic [7:0] O_FREEZE = 8'b00000000;
   localparam logic [7:0] O_REDIR  = 8'b11111110;
   localparam logic [7:0] O_LUSE   = 8'b00111010;
   localparam logic [7:0] O_FMISS  = 8'b01111100;
   localparam logic [7:0] O_HALTED = 8'b00000001;
   localparam int         MAXC     = 65535;

   pipeline_ctrl_if #(.CNT_W(16)) bus ();
   pipeline_ctrl_if #(.CNT_W(4))  bus4 ();
   pipeline_ctrl #(.CNT_W(16)) dut  (.CLK(CLK), .RST(RST), .pif(bus));
   pipeline_ctrl #(.CNT_W(4))  dut4 (.CLK(CLK), .RST(RST), .pif(bus4));

   logic [7:0] outs, outs4;
   assign outs  = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                   bus.ifid_flush, bus.idex_flush, bus.halted};
   assign outs4 = {bus4.pc_en, bus4.ifid_en, bus4.idex_en, bus4.exmem_en, bus4.memwb_en,
                   bus4.ifid_flush, bus4.idex_flush, bus4.halted};

   // reference model: halted / waiting-on-memory / fetch-owed flags and a stall tally
   bit m_halted, m_waiting, m_pend;
   int m_stalls;

   function automatic logic [7:0] expect_outs();
      logic hazard;
      hazard = bus.idex_dREN && bus.idex_rt != 0 &&
               (bus.idex_rt == bus.ifid_rs || bus.idex_rt == bus.ifid_rt);
      if (m_halted)                                                   return O_HALTED;
      if (m_waiting && !bus.dhit)                                     return O_FREEZE;
      if (!m_waiting && bus.halt_mem)                                 return O_FREEZE;
      if (!m_waiting && (bus.dREN_mem || bus.dWEN_mem) && !bus.dhit)  return O_FREEZE;
      if (bus.redirect_mem)                                           return O_REDIR;
      if (hazard)                                                     return O_LUSE;
      if (!(bus.ihit || m_pend))                                      return O_FMISS;
      return O_RUN;
   endfunction

   task automatic model_step();
      logic [7:0] e;
      e = expect_outs();
      if (!m_halted) begin
         if (!e[7]) m_stalls = (m_stalls < MAXC) ? m_stalls + 1 : MAXC;
         if (e[7])          m_pend = 1'b0;
         else if (bus.ihit) m_pend = 1'b1;
         if (!m_waiting && bus.halt_mem) m_halted = 1'b1;
         else if (!m_waiting && (bus.dREN_mem || bus.dWEN_mem) && !bus.dhit) m_waiting = 1'b1;
         else if (m_waiting && bus.dhit) m_waiting = 1'b0;
      end
   endtask

   task automatic drive(input logic ih, dh, dr, dw, hm, rd, ldr,
                        input logic [4:0] rtx, rs, rt);
      @(negedge CLK);
      bus.ihit = ih;  bus.dhit = dh;  bus.dREN_mem = dr;  bus.dWEN_mem = dw;
      bus.halt_mem = hm;  bus.redirect_mem = rd;  bus.idex_dREN = ldr;
      bus.idex_rt = rtx;  bus.ifid_rs = rs;  bus.ifid_rt = rt;
      #1;
   endtask

   task automatic idle(input logic ih);
      drive(ih, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic do_reset();
      idle(1'b1);
      RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      m_halted = 0; m_waiting = 0; m_pend = 0; m_stalls = 0;
   endtask

   task automatic test_reset();
      idle(1'b1);
      RST = 1'b1;
      #1;
      if (outs !== O_RUN) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs, O_RUN); end
      checks++;
      if (bus.stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_cnt); end
      checks++;
      @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   task automatic test_steady();
      int bad = 0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         idle(1'b1);
         if (outs !== O_RUN) bad++;
      end
      if (bad != 0) begin failures++; $display("FAIL steady_outs bad_cycles=%0d exp=0", bad); end
      checks++;
      idle(1'b1);
      if (bus.stall_cnt !== 16'd0) begin failures++; $display("FAIL steady_cnt got=%0d exp=0", bus.stall_cnt); end
      checks++;
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0);
      if (outs !== O_LUSE) begin failures++; $display("FAIL lu_rs got=%b exp=%b", outs, O_LUSE); end
      checks++;
      idle(1'b1);
      if (bus.stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", bus.stall_cnt); end
      checks++;
      drive(1, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
      if (outs !== O_RUN) begin failures++; $display("FAIL lu_r0 got=%b exp=%b", outs, O_RUN); end
      checks++;
      drive(1, 0, 0, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7);
      if (outs !== O_LUSE) begin failures++; $display("FAIL lu_rt got=%b exp=%b", outs, O_LUSE); end
      checks++;
      idle(1'b1);
      if (bus.stall_cnt !== 16'd2) begin failures++; $display("FAIL lu_cnt2 got=%0d exp=2", bus.stall_cnt); end
      checks++;
   endtask

   task automatic test_dwait();
      logic [7:0] seen [4];
      logic [7:0] want [4];
      want = '{O_FREEZE, O_FREEZE, O_FREEZE, O_RUN};
      do_reset();
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); seen[0] = outs;
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0); seen[1] = outs;
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); seen[2] = outs;
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0); seen[3] = outs;
      for (int i = 0; i < 4; i++) begin
         if (seen[i] !== want[i]) begin failures++; $display("FAIL dwait_c%0d got=%b exp=%b", i, seen[i], want[i]); end
         checks++;
      end
      idle(1'b0);
      if (outs !== O_FMISS) begin failures++; $display("FAIL dwait_pend_clr got=%b exp=%b", outs, O_FMISS); end
      checks++;
      if (bus.stall_cnt !== 16'd3) begin failures++; $display("FAIL dwait_cnt got=%0d exp=3", bus.stall_cnt); end
      checks++;
      // reset mid-wait must leave no owed fetch behind
      do_reset();
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      do_reset();
      idle(1'b0);
      if (outs !== O_FMISS) begin failures++; $display("FAIL dwait_rst got=%b exp=%b", outs, O_FMISS); end
      checks++;
      // redirect on the wait exit cycle
      do_reset();
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0);
      if (outs !== O_REDIR) begin failures++; $display("FAIL dwait_redir got=%b exp=%b", outs, O_REDIR); end
      checks++;
   endtask

   task automatic test_redirect_load_use();
      do_reset();
      drive(1, 0, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0);
      if (outs !== O_REDIR) begin failures++; $display("FAIL redir_lu got=%b exp=%b", outs, O_REDIR); end
      checks++;
      idle(1'b1);
      if (bus.stall_cnt !== 16'd0) begin failures++; $display("FAIL redir_cnt got=%0d exp=0", bus.stall_cnt); end
      checks++;
   endtask

   task automatic test_halt();
      int bad = 0;
      do_reset();
      drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      if (outs !== O_FREEZE) begin failures++; $display("FAIL halt_entry got=%b exp=%b", outs, O_FREEZE); end
      checks++;
      for (int i = 0; i < 10; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0, 0);
         if (outs !== O_HALTED || bus.stall_cnt !== 16'd1) bad++;
      end
      if (bad != 0) begin failures++; $display("FAIL halt_hold bad_cycles=%0d exp=0", bad); end
      checks++;
      idle(1'b1);
      RST = 1'b1;
      #1;
      if (outs !== O_RUN) begin failures++; $display("FAIL halt_rst got=%b exp=%b", outs, O_RUN); end
      checks++;
      @(posedge CLK);
      #1 RST = 1'b0;
      idle(1'b1);
      if (outs !== O_RUN || bus.stall_cnt !== 16'd0) begin
         failures++; $display("FAIL halt_after_rst got=%b cnt=%0d exp=%b cnt=0", outs, bus.stall_cnt, O_RUN);
      end
      checks++;
   endtask

   task automatic test_saturate();
      int bad = 0;
      int exp;
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      for (int k = 0; k < 21; k++) begin
         @(negedge CLK);
         #1;
         exp = (k < 15) ? k : 15;
         if (bus4.stall_cnt !== exp[3:0] || outs4 !== O_FMISS) bad++;
      end
      if (bad != 0) begin failures++; $display("FAIL sat_seq bad_cycles=%0d exp=0", bad); end
      checks++;
      if (bus4.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_final got=%0d exp=15", bus4.stall_cnt); end
      checks++;
   endtask

   task automatic test_random();
      int halt_cycles = 0;
      logic [7:0] e;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         if (m_halted && halt_cycles > 4) begin
            do_reset();
            halt_cycles = 0;
         end
         drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         e = expect_outs();
         if (outs !== e) begin failures++; $display("FAIL rand_outs cyc=%0d got=%b exp=%b", n, outs, e); end
         checks++;
         if (bus.stall_cnt !== 16'(m_stalls)) begin
            failures++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", n, bus.stall_cnt, m_stalls);
         end
         checks++;
         model_step();
         if (m_halted) halt_cycles++;
      end
   endtask

   initial begin
      bus.ihit = 0; bus.dhit = 0; bus.dREN_mem = 0; bus.dWEN_mem = 0; bus.halt_mem = 0;
      bus.redirect_mem = 0; bus.idex_dREN = 0; bus.idex_rt = 0; bus.ifid_rs = 0; bus.ifid_rt = 0;
      bus4.ihit = 0; bus4.dhit = 0; bus4.dREN_mem = 0; bus4.dWEN_mem = 0; bus4.halt_mem = 0;
      bus4.redirect_mem = 0; bus4.idex_dREN = 0; bus4.idex_rt = 0; bus4.ifid_rs = 0; bus4.ifid_rt = 0;
      test_reset();
      test_steady();
      test_load_use();
      test_dwait();
      test_redirect_load_use();
      test_halt();
      test_saturate();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-002 SHALL have ports:
- CLK  in  1  clock, posedge.
- RST  in  1  asynchronous reset, active-high.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- dREN_mem, dWEN_mem  in  1 each  MEM-stage data read/write request.
- halt_mem  in  1  halt instruction in MEM.
- redirect_mem  in  1  taken branch/j/jal/jr resolved in MEM.
- idex_dREN  in  1  load in EX.
- idex_rt  in  5  EX load destination.
- ifid_rs, ifid_rt  in  5 each  ID sources.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage/PC update enables.
- ifid_flush, idex_flush  out  1 each  load bubble into that latch.
- halted  out  1  sticky halt.
- stall_cnt  out  CNT_W  PC-stall cycle count.

Function
REQ-003 SHALL implement state register with states RUN, DWAIT, HALT.
REQ-004 SHALL keep one flag if_pend: an ihit seen while frozen.
REQ-005 SHALL drive enables/flushes combinationally from state, if_pend and inputs.
- Latency to the pipeline latches: same cycle.
REQ-006 In RUN, SHALL apply the first matching rule:
- (a) halt_mem: all enables 0, flushes 0; next state HALT.
- (b) (dREN_mem|dWEN_mem)&!dhit: all enables 0, flushes 0; next state DWAIT.
- (c) redirect_mem: all enables 1, ifid_flush=1, idex_flush=1.
- (d) load-use, i.e. idex_dREN & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt): pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1.
- (e) !(ihit|if_pend): pc_en=0, ifid_flush=1, other enables 1.
- (f) otherwise: all enables 1, flushes 0.
REQ-007 In DWAIT, SHALL hold all enables 0 and all flushes 0.
- Exit: on dhit, evaluate the RUN rules (b)-(f) that same cycle with (b) suppressed; next state RUN.
- halt_mem is held by the frozen latch, so it is not sampled in DWAIT.
REQ-008 if_pend SHALL set when ihit=1 and pc_en=0 in RUN or DWAIT.
- if_pend SHALL clear on any cycle with pc_en=1.
- Set and clear in the same cycle: clear wins.
REQ-009 In HALT, SHALL drive all enables 0 and flushes 0, and halted=1.
- HALT is left only by reset.
REQ-010 A flush output SHALL assert only when its latch enable is also 1 (a bubble is a load).
REQ-011 stall_cnt SHALL increment by 1 on every cycle with pc_en=0 and state!=HALT.
- stall_cnt saturates at all-ones: no wrap.
REQ-012 Simultaneous redirect_mem and load-use SHALL resolve as a redirect (rule c); the squashed ID instruction causes no stall.
REQ-013 redirect_mem during the DWAIT exit cycle SHALL apply rule (c).

Reset
REQ-014 RST=1 SHALL asynchronously force:
- state=RUN, if_pend=0, stall_cnt=0, halted=0;
- combinational outputs then follow RUN rules.
REQ-015 RST asserted mid-DWAIT or in HALT SHALL abandon the wait/halt with no residual if_pend.

Verification
REQ-016 Benches SHALL cover these scenarios:
- V1: reset, ihit=1 steady, no hazards -> all enables 1, flushes 0, stall_cnt=0 after 20 cycles.
- V2: idex_dREN=1, idex_rt=5, ifid_rs=5, one cycle -> pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Same stimulus with idex_rt=0 -> no stall.
- V3: dREN_mem=1, dhit low 3 cycles then high; ihit pulses during the wait -> 3 frozen cycles, all enables 1 on the dhit cycle, no fetch lost (if_pend 1 then 0), stall_cnt=3 (dhit cycle not counted).
- V4: redirect_mem and load-use together -> ifid_flush=idex_flush=1, pc_en=1, stall_cnt unchanged.
- V5: halt_mem=1 -> halted=1 next cycle, enables 0 for 10 cycles despite ihit/dhit, stall_cnt frozen; RST pulse -> halted=0, state RUN.
- V6: preload stall_cnt near all-ones with CNT_W=4, 20 ihit-miss cycles -> stall_cnt holds 15.
